dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 256x16 data memory between two requesters: the processor controller
//  (load/store path) and an external port (program loader / debug). Round-robin arbitration,
//  one access in flight at a time; returns read data with a valid pulse to the owning requester.
//  Sits between the controller/datapath D_addr/D_wr/read-data signals and the data memory.
// PARAMETERS
//  AW      8   memory address width
//  DW      16  memory data width
//  RD_LAT  1   cycles from the ACCESS clock edge to valid mem_rdata (legal 1..3)
// PORTS
//  Clk         in   1   system clock, all state updates on rising edge
//  Rst         in   1   asynchronous, active-low reset
//  cpu_req     in   1   processor access request, held until cpu_gnt
//  cpu_wr      in   1   1 = write, 0 = read; stable while cpu_req high
//  cpu_addr    in   AW  access address; stable while cpu_req high
//  cpu_wdata   in   DW  write data; stable while cpu_req high
//  cpu_gnt     out  1   one-cycle pulse: processor access issued to memory this cycle
//  cpu_rvalid  out  1   one-cycle pulse: cpu_rdata valid (reads only)
//  cpu_rdata   out  DW  read data returned to processor
//  ext_req / ext_wr / ext_addr / ext_wdata   in   1/1/AW/DW   external port, same rules as cpu_*
//  ext_gnt / ext_rvalid / ext_rdata          out  1/1/DW      external port, same rules as cpu_*
//  mem_addr    out  AW  memory address
//  mem_wr      out  1   memory write enable
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid RD_LAT cycles after address sampled
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset (Rst=0, immediate): state=IDLE, owner=none, rr pointer last=EXT (CPU wins first tie);
//   all outputs 0 (gnt, rvalid, mem_wr, busy = 0; mem_addr, mem_wdata, rdata = 0).
//  FSM states: IDLE, ACCESS, WAIT.
//  IDLE: no req -> stay. Exactly one req -> latch it as owner, -> ACCESS. Both req -> latch the
//   requester that is not `last`, -> ACCESS. Outputs all 0 in IDLE.
//  ACCESS (exactly 1 cycle): owner's gnt=1; mem_addr=owner addr; mem_wdata=owner wdata;
//   mem_wr=owner wr; last<=owner. Owner wr=1 -> IDLE. Owner wr=0 -> WAIT, counter<=RD_LAT.
//  WAIT: mem_addr held at latched address, mem_wr=0; counter decrements each cycle; in the
//   RD_LAT-th cycle after ACCESS, owner rvalid=1 and owner rdata=mem_rdata (combinational pass),
//   -> IDLE. Non-owner rvalid/rdata stay 0.
//  Latency: req seen high in IDLE -> gnt next cycle. Write occupies 2 cycles (IDLE+ACCESS);
//   read occupies RD_LAT+2. Requests arriving during ACCESS/WAIT wait for IDLE.
//  Requester rules: req/wr/addr/wdata held stable until gnt; req deasserted the cycle after gnt
//   unless a new access is wanted. Dropping req before gnt is a protocol violation (no recovery).
//  Never more than one gnt or rvalid high in any cycle; gnt and rvalid never high together.
//  Back-to-back: requester holding req after gnt is re-arbitrated normally in next IDLE, so two
//   continuous requesters alternate strictly CPU, EXT, CPU, ...
//  Reset mid-operation: in-flight read discarded, no rvalid issued; requester must reissue.
//  RD_LAT outside 1..3 is illegal (elaboration check).
// TESTING
//  1 CPU write: cpu_req=1,wr=1,addr=8'h12,wdata=16'hBEEF -> next cycle cpu_gnt=1,mem_wr=1,
//    mem_addr=8'h12,mem_wdata=16'hBEEF for exactly 1 cycle; busy=0 the cycle after.
//  2 CPU read, RD_LAT=1, mem[8'h05]=16'h1234 -> cpu_gnt at cycle N, cpu_rvalid=1,
//    cpu_rdata=16'h1234 at N+1; ext_rvalid=0 throughout.
//  3 Both request writes continuously from reset release -> grants CPU,EXT,CPU,EXT, one per
//    2 cycles; never both gnt high.
//  4 RD_LAT=3 ext read addr 8'hA0 with cpu_req raised during WAIT -> ext_rvalid exactly 3
//    cycles after ext_gnt, mem_addr=8'hA0 held throughout, cpu_gnt 2 cycles after ext_rvalid.
//  5 Rst=0 mid-WAIT -> all outputs 0 same cycle (async), no rvalid; after release with both
//    req -> CPU granted first.
//  6 No requests for 20 cycles -> stays IDLE, busy=0, mem_wr=0, all gnt/rvalid=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the processor
// controller and an external loader/debug port; one access in flight at a time.
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_wr,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be in 1..3");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_e;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          ext_gnt_q, ext_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic          busy_q, busy_d;
  logic          pick_ext;
  logic          rd_done_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 1'b0;
    mem_wdata_d = '0;
    cpu_gnt_d   = 1'b0;
    ext_gnt_d   = 1'b0;
    pick_ext    = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_addr_d = '0;
        if (cpu_req || ext_req) begin
          // EXT wins only when alone or when CPU was the last owner
          pick_ext    = ext_req && (!cpu_req || last_q == OWN_CPU);
          owner_d     = pick_ext ? OWN_EXT : OWN_CPU;
          mem_addr_d  = pick_ext ? ext_addr : cpu_addr;
          mem_wr_d    = pick_ext ? ext_wr : cpu_wr;
          mem_wdata_d = pick_ext ? ext_wdata : cpu_wdata;
          cpu_gnt_d   = !pick_ext;
          ext_gnt_d   = pick_ext;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        last_d = owner_q;
        if (mem_wr_q) begin
          state_d    = S_IDLE;
          mem_addr_d = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 2'(RD_LAT);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d    = S_IDLE;
          mem_addr_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        mem_addr_d = '0;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    // rvalid is registered: asserted for the WAIT cycle whose count is 1
    rd_done_d    = (state_d == S_WAIT) && (cnt_d == 2'd1);
    cpu_rvalid_d = rd_done_d && (owner_d == OWN_CPU);
    ext_rvalid_d = rd_done_d && (owner_d == OWN_EXT);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_q       <= OWN_EXT;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ext_gnt_q    <= ext_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ext_gnt    = ext_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid_q ? mem_rdata : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level timing model predicts
// grants, read returns and memory-bus activity; a monitor checks every cycle.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RD_LAT = 3;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          cpu_req, cpu_wr, ext_req, ext_wr;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, mem_wr, busy;
  logic [DW-1:0] cpu_rdata, ext_rdata;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Memory: synchronous read with RD_LAT-stage output pipeline
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [RD_LAT];
  logic          fill_en;
  logic [7:0]    fill_idx;

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  always @(posedge Clk) begin
    if (fill_en) mem[fill_idx] <= init_val(fill_idx);
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: ev = {ext_rvalid, cpu_rvalid, ext_gnt, cpu_gnt}
  typedef struct { int cyc; logic [3:0] ev; logic [DW-1:0] data; } ev_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic chk_wd; } bus_t;
  ev_t  exp_q[$];
  bus_t exp_bus[int];
  bit   mon_en = 1'b0;

  logic [3:0]    m_ev_exp, m_ev_act;
  logic [DW-1:0] m_data;
  bus_t          m_b;

  initial forever begin
    @(negedge Clk);
    if (mon_en) begin
      m_ev_exp = '0;
      m_data   = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        m_ev_exp = exp_q[0].ev;
        m_data   = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      m_ev_act = {ext_rvalid, cpu_rvalid, ext_gnt, cpu_gnt};
      chk("gnt_rvalid", 64'(m_ev_act), 64'(m_ev_exp));
      chk("cpu_rdata", 64'(cpu_rdata), m_ev_exp[2] ? 64'(m_data) : 64'd0);
      chk("ext_rdata", 64'(ext_rdata), m_ev_exp[3] ? 64'(m_data) : 64'd0);
      if (exp_bus.exists(cyc)) begin
        m_b = exp_bus[cyc];
        exp_bus.delete(cyc);
        chk("busy", 64'(busy), 64'd1);
        chk("mem_wr", 64'(mem_wr), 64'(m_b.wr));
        chk("mem_addr", 64'(mem_addr), 64'(m_b.addr));
        if (m_b.chk_wd) chk("mem_wdata", 64'(mem_wdata), 64'(m_b.wdata));
      end else begin
        chk("idle_bus", 64'({busy, mem_wr, mem_addr, mem_wdata}), 64'd0);
      end
    end
  end

  // Reference model: requester agents plus transaction-level arbitration timing
  bit            pend [2];
  logic          p_wr [2];
  logic [7:0]    p_addr [2];
  logic [DW-1:0] p_wd [2];
  logic [DW-1:0] ref_mem [256];
  int            idle_at;
  int            last_p;

  task automatic reset_model();
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_p  = 1;
    idle_at = cyc;
    exp_q.delete();
    exp_bus.delete();
  endtask

  task automatic inject(input int p, input logic wr, input logic [7:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d;
  endtask

  task automatic predict(input int t);
    int   w;
    bus_t b;
    if (t >= idle_at && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = (last_p == 1) ? 0 : 1;
      else w = pend[0] ? 0 : 1;
      b.wr = p_wr[w]; b.addr = p_addr[w]; b.wdata = p_wd[w]; b.chk_wd = 1'b1;
      exp_bus[t+1] = b;
      exp_q.push_back('{t+1, (w == 0) ? 4'b0001 : 4'b0010, '0});
      if (p_wr[w]) begin
        ref_mem[p_addr[w]] = p_wd[w];
        idle_at = t + 2;
      end else begin
        for (int k = 1; k <= RD_LAT; k++) exp_bus[t+1+k] = '{1'b0, p_addr[w], '0, 1'b0};
        exp_q.push_back('{t+1+RD_LAT, (w == 0) ? 4'b0100 : 4'b1000, ref_mem[p_addr[w]]});
        idle_at = t + 2 + RD_LAT;
      end
      last_p  = w;
      pend[w] = 1'b0;
    end
  endtask

  // Drives one cycle of inputs; entered and left at negedge+1
  task automatic step(input int pct);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if (int'($urandom_range(99)) < pct)
          inject(p, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
        else begin
          p_wr[p] = 1'($urandom_range(1)); p_addr[p] = 8'($urandom); p_wd[p] = 16'($urandom);
        end
      end
    end
    cpu_req = pend[0]; cpu_wr = p_wr[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wd[0];
    ext_req = pend[1]; ext_wr = p_wr[1]; ext_addr = p_addr[1]; ext_wdata = p_wd[1];
    predict(cyc);
    @(negedge Clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] || pend[1] || exp_q.size() > 0) && n < 200) begin
      step(0);
      n++;
    end
  endtask

  task automatic inputs_zero();
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_wr = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata,
                mem_addr, mem_wr, mem_wdata, busy});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    inputs_zero();
    fill_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fill_idx   = 8'(i);
      ref_mem[i] = init_val(8'(i));
      @(negedge Clk);
    end
    fill_en = 1'b0;
    chk("reset_outputs", all_outs(), 64'd0);
    #1;
    Rst = 1'b1;
    reset_model();
    mon_en = 1'b1;

    // Quiet interval
    repeat (20) step(0);

    // Directed CPU write, then write/read of a known word
    inject(0, 1'b1, 8'h12, 16'hBEEF); drain();
    inject(0, 1'b1, 8'h05, 16'h1234); drain();
    inject(0, 1'b0, 8'h05, 16'h0000); drain();

    // Two continuous writers must alternate
    repeat (16) begin
      if (!pend[0]) inject(0, 1'b1, 8'($urandom_range(15)), 16'($urandom));
      if (!pend[1]) inject(1, 1'b1, 8'($urandom_range(15)), 16'($urandom));
      step(0);
    end
    drain();

    // EXT read with CPU request arriving during the wait
    inject(1, 1'b0, 8'hA0, 16'h0000);
    repeat (3) step(0);
    inject(0, 1'b1, 8'h33, 16'hC0DE);
    drain();

    // Reset in the middle of a read wait
    inject(1, 1'b0, 8'hA0, 16'h0000);
    repeat (2) step(0);
    mon_en = 1'b0;
    Rst = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    inputs_zero();
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (4) @(negedge Clk);
    #1;
    Rst = 1'b1;
    reset_model();
    mon_en = 1'b1;
    inject(0, 1'b1, 8'h44, 16'h4444);
    inject(1, 1'b1, 8'h55, 16'h5555);
    drain();

    // Random traffic
    repeat (400) step(35);
    drain();
    repeat (3) step(0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
